// File: rtl/four_two_enc_pkg.sv
// Shared constants, state type and helpers for the 4-to-2 round-robin encoder.
package four_two_enc_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Expand a request index into the matching one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/four_to_two_rr_enc_pick.sv
// Combinational request picker: fixed (lowest index wins) or round-robin
// scanning upward from the pointer with wrap. Also flags multi-hot requests.
module rr_prio_pick
  import four_two_enc_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_mode,   // 1 = round-robin, 0 = fixed
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found,
  output logic             o_multi
);

  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_pos;

  assign o_found = |i_req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi = |(i_req & (i_req - N_REQ'(1)));

  // Scan from the farthest position back to the start so the nearest hit wins.
  always_comb begin
    w_start = i_mode ? i_ptr : '0;
    w_pos   = '0;
    o_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = w_start + IDX_W'(k);
      if (i_req[w_pos]) o_idx = w_pos;
    end
  end

endmodule

// File: rtl/four_to_two_rr_enc.sv
// Sequential 4-to-2 encoder with valid/ready handoff and one-cycle grant pulse.
//   state | meaning
//   IDLE  | no pending selection, capture on En with any request
//   HOLD  | Out/Multi frozen and Valid high until Ready handshake
module four_to_two_rr_enc
  import four_two_enc_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_out,
  output logic             o_valid,
  output logic             o_multi,
  output logic [N_REQ-1:0] o_grant
);

  localparam logic LP_RR = (PRIO_MODE == PRIO_RR);

  state_e           r_state;
  state_e           w_next_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_out;
  logic             r_multi;
  logic [N_REQ-1:0] r_grant;

  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_multi;
  logic             w_capture;
  logic             w_handshake;

  rr_prio_pick u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .i_mode  (LP_RR),
    .o_idx   (w_idx),
    .o_found (w_found),
    .o_multi (w_multi)
  );

  // State register; reset drops any pending selection immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state: capture on enabled non-zero request, release on Ready.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_en && w_found) w_next_state = HOLD;
      HOLD:    if (i_ready)         w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output/strobe decode from the current state.
  always_comb begin
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE:    w_capture   = i_en && w_found;
      HOLD:    w_handshake = i_ready;
      default: ;
    endcase
  end

  // Datapath registers: index/multi on capture, grant pulse and pointer on handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out   <= '0;
      r_multi <= 1'b0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_capture) begin
        r_out   <= w_idx;
        r_multi <= w_multi;
      end
      r_grant <= w_handshake ? idx_to_onehot(r_out) : '0;
      // Fixed mode never moves the pointer so the scan always starts at 0.
      if (w_handshake && LP_RR) r_ptr <= r_out + IDX_W'(1);
    end
  end

  assign o_out   = r_out;
  assign o_valid = (r_state == HOLD);
  assign o_multi = r_multi;
  assign o_grant = r_grant;

endmodule
